// File: rtl/regfile_writeback.sv
// In-order write-back FIFO that merges ALU and load results into the register
// file's single write port. Optional forwarding CAM enabled by `define WB_FWD_EN.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [AW-1:0]              alu_wa,
  input  logic [DW-1:0]              alu_wd,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [AW-1:0]              mem_wa,
  input  logic [DW-1:0]              mem_wd,
  input  logic                       hold,
  output logic                       write,
  output logic [AW-1:0]              wa,
  output logic [DW-1:0]              wd,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [AW-1:0]              fwd_ra,
  output logic                       fwd_hit,
  output logic [DW-1:0]              fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a result transfers on a rising edge where valid & ready are both
  // high. Ready is a function of registered state only, so valid may depend on
  // ready but never the reverse; a producer holds valid/data until accepted.

  logic [AW-1:0] wa_mem [DEPTH];
  logic [DW-1:0] wd_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q;
  logic          rr;
  logic [CW-1:0] free;
  logic          alu_acc, mem_acc, pop;
  logic          rr_toggle;

  assign count = count_q;
  assign free  = CW'(DEPTH) - count_q;

  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (free >= CW'(2)) begin
      alu_ready = 1'b1;
      mem_ready = 1'b1;
    end else if (free == CW'(1)) begin
      alu_ready = ~rr;
      mem_ready = rr;
    end
  end

  assign alu_acc   = alu_valid & alu_ready;
  assign mem_acc   = mem_valid & mem_ready;
  assign pop       = write;
  assign rr_toggle = (free == CW'(1)) & ((~rr & alu_acc) | (rr & mem_acc));

  assign write = (count_q != '0) & ~hold;
  assign wa    = (count_q != '0) ? wa_mem[rd_ptr] : '0;
  assign wd    = (count_q != '0) ? wd_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      rr      <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr + PW'(pop);
      wr_ptr  <= wr_ptr + PW'(alu_acc) + PW'(mem_acc);
      count_q <= count_q + CW'(alu_acc) + CW'(mem_acc) - CW'(pop);
      if (rr_toggle) rr <= ~rr;
    end
  end

  // On a dual accept the load goes in first, so the ALU result is younger.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (mem_acc) begin
        wa_mem[wr_ptr] <= mem_wa;
        wd_mem[wr_ptr] <= mem_wd;
      end
      if (alu_acc) begin
        wa_mem[wr_ptr + PW'(mem_acc)] <= alu_wa;
        wd_mem[wr_ptr + PW'(mem_acc)] <= alu_wd;
      end
    end
  end

`ifdef WB_FWD_EN
  // Scan oldest to youngest so the last match seen is the youngest one.
  logic [PW-1:0] idx;
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count_q) && (wa_mem[idx] == fwd_ra)) begin
        fwd_hit  = 1'b1;
        fwd_data = wd_mem[idx];
      end
    end
  end
`else
  logic unused_fwd_ra;
  assign unused_fwd_ra = ^fwd_ra;
  assign fwd_hit       = 1'b0;
  assign fwd_data      = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a reference model of occupancy and
// round-robin state predicts readys, and an expected queue predicts writes.
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, mem_valid, hold;
  logic [AW-1:0] alu_wa, mem_wa, fwd_ra;
  logic [DW-1:0] alu_wd, mem_wd;
  logic          alu_ready, mem_ready, write, fwd_hit;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd, fwd_data;
  logic [CW-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic             m_rr = 1'b0;

  regfile_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .hold(hold), .write(write), .wa(wa), .wd(wd), .count(count),
    .fwd_ra(fwd_ra), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic h);
    alu_valid = av; alu_wa = aa; alu_wd = ad;
    mem_valid = mv; mem_wa = ma; mem_wd = md;
    hold = h;
  endtask

  // One checked clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int               sz, fr;
    logic             e_ar, e_mr, e_wr, aacc, macc, e_hit;
    logic [AW+DW-1:0] head;
    logic [DW-1:0]    e_fd;
    @(negedge clk);
    sz   = exp_q.size();
    fr   = DEPTH - sz;
    e_ar = (fr >= 2) || (fr == 1 && !m_rr);
    e_mr = (fr >= 2) || (fr == 1 && m_rr);
    e_wr = (sz != 0) && !hold;
    head = (sz != 0) ? exp_q[0] : '0;
    check("alu_ready", 64'(alu_ready), 64'(e_ar));
    check("mem_ready", 64'(mem_ready), 64'(e_mr));
    check("count", 64'(count), 64'(sz));
    check("write", 64'(write), 64'(e_wr));
    check("wa", 64'(wa), 64'(head[AW+DW-1:DW]));
    check("wd", 64'(wd), 64'(head[DW-1:0]));
    e_hit = 1'b0;
    e_fd  = '0;
`ifdef WB_FWD_EN
    for (int i = 0; i < sz; i++) begin
      if (exp_q[i][AW+DW-1:DW] == fwd_ra) begin
        e_hit = 1'b1;
        e_fd  = exp_q[i][DW-1:0];
      end
    end
`endif
    check("fwd_hit", 64'(fwd_hit), 64'(e_hit));
    check("fwd_data", 64'(fwd_data), 64'(e_fd));
    aacc = alu_valid && e_ar;
    macc = mem_valid && e_mr;
    @(posedge clk);
    if (!reset) begin
      exp_q.delete();
      m_rr = 1'b0;
    end else begin
      if (e_wr) void'(exp_q.pop_front());
      if (macc) exp_q.push_back({mem_wa, mem_wd});
      if (aacc) exp_q.push_back({alu_wa, alu_wd});
      if (fr == 1 && ((!m_rr && aacc) || (m_rr && macc))) m_rr = ~m_rr;
    end
    #1;
  endtask

  task automatic idle(input logic h, input int n);
    drive(1'b0, '0, '0, 1'b0, '0, '0, h);
    repeat (n) cycle();
  endtask

  initial begin
    fwd_ra = '0;
    // reset held for two edges with traffic offered
    reset = 1'b0;
    drive(1'b1, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    cycle();
    reset = 1'b1;
    idle(1'b0, 1);

    // single ALU result
    drive(1'b1, 6'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0);
    cycle();
    idle(1'b0, 2);

    // dual accept, load ahead of ALU, held then released
    drive(1'b1, 6'd3, 32'd2, 1'b1, 6'd3, 32'd1, 1'b1);
    cycle();
    idle(1'b1, 2);
    idle(1'b0, 3);

    // fill to full with round-robin at free==1
    drive(1'b1, 6'd10, 32'hA0, 1'b0, '0, '0, 1'b1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(11 + i), DW'($urandom), 1'b1, AW'(20 + i), DW'($urandom), 1'b1);
      cycle();
    end
    idle(1'b0, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, AW'(30 + i), DW'($urandom), 1'b1, AW'(40 + i), DW'($urandom), 1'b1);
      cycle();
    end
    idle(1'b0, 6);

    // reset in the middle of traffic
    drive(1'b1, 6'd12, 32'h12, 1'b1, 6'd13, 32'h13, 1'b1);
    cycle();
    drive(1'b1, 6'd14, 32'h14, 1'b0, '0, '0, 1'b1);
    cycle();
    reset = 1'b0;
    drive(1'b1, 6'd15, 32'h15, 1'b1, 6'd16, 32'h16, 1'b1);
    cycle();
    reset = 1'b1;
    idle(1'b0, 1);
    drive(1'b1, 6'd0, 32'h0BAD, 1'b0, '0, '0, 1'b0);
    cycle();
    idle(1'b0, 2);

    // forwarding: youngest match wins
    drive(1'b1, 6'd7, 32'd10, 1'b0, '0, '0, 1'b1);
    cycle();
    drive(1'b1, 6'd7, 32'd20, 1'b0, '0, '0, 1'b1);
    cycle();
    fwd_ra = 6'd7;
    idle(1'b1, 1);
    fwd_ra = 6'd8;
    idle(1'b1, 1);
    fwd_ra = 6'd7;
    idle(1'b0, 3);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
            ($urandom_range(0, 3) == 0));
      fwd_ra = AW'($urandom_range(0, 7));
      reset  = ($urandom_range(0, 60) != 0);
      cycle();
    end
    reset = 1'b1;
    idle(1'b0, DEPTH + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
